pht_update_scheduler: RTL and testbench

PHT_UPDATE_SCHEDULER -- requirements
Module: pht_update_scheduler

---
 rtl/pht_update_scheduler.sv | 148 ++++++++++++++
 tb/tb_pht_update_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pht_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pht_update_scheduler
// Brief    : Serialises two-lane PHT counter updates through a FIFO onto a
//            single write port, with a power-up/flush counter init sweep.
// Revision : 1.0 - initial release
// ============================================================================
module pht_update_scheduler #(
    parameter int         INDEX_WIDTH = 11,
    parameter int         QUEUE_DEPTH = 32,
    parameter logic [1:0] INIT_VALUE  = 2'b01
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [1:0]                     updValid,
    input  logic [1:0]                     updIsCondBr,
    input  logic [2*INDEX_WIDTH-1:0]       updIndex,
    input  logic [3:0]                     updPrev,
    input  logic [1:0]                     updTaken,
    input  logic                           portBusy,
    output logic                           phtWE,
    output logic [INDEX_WIDTH-1:0]         phtWA,
    output logic [1:0]                     phtWV,
    output logic                           full,
    output logic                           initBusy,
    output logic                           overflow,
    output logic [$clog2(QUEUE_DEPTH):0]   count
);

    localparam int                 c_pw          = $clog2(QUEUE_DEPTH);
    localparam logic [INDEX_WIDTH-1:0] c_last_index = '1;
    localparam logic [c_pw+1:0]    c_depth       = (c_pw+2)'(QUEUE_DEPTH);
    localparam logic [c_pw:0]      c_full_thresh = (c_pw+1)'(QUEUE_DEPTH-2);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [INDEX_WIDTH-1:0]    r_sweep;
    logic [c_pw-1:0]           r_wptr;
    logic [c_pw-1:0]           r_rptr;
    logic [c_pw:0]             r_count;
    logic                      r_overflow;
    logic [INDEX_WIDTH-1:0]    r_q_idx [QUEUE_DEPTH];
    logic [1:0]                r_q_val [QUEUE_DEPTH];

    logic [1:0]                w_elig;
    logic [1:0]                w_acc;
    logic [INDEX_WIDTH-1:0]    w_lane_idx [2];
    logic [1:0]                w_lane_val [2];
    logic                      w_pop;
    logic                      w_drop;
    logic [c_pw+1:0]           w_free;
    logic [c_pw:0]             w_count_next;
    logic [c_pw-1:0]           w_slot1;

    // Saturating counter update is resolved at enqueue time so the queue
    // holds final write values.
    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [1:0] w_prev;
        assign w_prev        = updPrev[2*l +: 2];
        assign w_lane_idx[l] = updIndex[l*INDEX_WIDTH +: INDEX_WIDTH];
        assign w_lane_val[l] = updTaken[l] ? ((w_prev == 2'd3) ? 2'd3 : w_prev + 2'd1)
                                           : ((w_prev == 2'd0) ? 2'd0 : w_prev - 2'd1);
        assign w_elig[l]     = updValid[l] & updIsCondBr[l] & (r_state == S_RUN) & ~flush;
    end

    always_comb begin
        w_state_next = r_state;
        phtWE        = 1'b0;
        w_pop        = 1'b0;
        if (!rst && !flush && !portBusy) begin
            if (r_state == S_INIT) begin
                phtWE = 1'b1;
                if (r_sweep == c_last_index) begin
                    w_state_next = S_RUN;
                end
            end else if (r_count != '0) begin
                phtWE = 1'b1;
                w_pop = 1'b1;
            end
        end
        // Slots left after the same-cycle pop; lane 0 claims first.
        w_free       = c_depth - {1'b0, r_count} + (c_pw+2)'(w_pop);
        w_acc[0]     = w_elig[0] && (w_free != '0);
        w_acc[1]     = w_elig[1] && (w_free > (c_pw+2)'(w_acc[0]));
        w_drop       = |(w_elig & ~w_acc);
        w_count_next = r_count + (c_pw+1)'(w_acc[0]) + (c_pw+1)'(w_acc[1])
                     - (c_pw+1)'(w_pop);
        w_slot1      = r_wptr + c_pw'(w_acc[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_sweep    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_state <= S_INIT;
            r_sweep <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_INIT && phtWE) begin
                r_sweep <= r_sweep + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_wptr  <= r_wptr + c_pw'(w_acc[0]) + c_pw'(w_acc[1]);
            r_count <= w_count_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_acc[0]) begin
                r_q_idx[r_wptr] <= w_lane_idx[0];
                r_q_val[r_wptr] <= w_lane_val[0];
            end
            if (w_acc[1]) begin
                r_q_idx[w_slot1] <= w_lane_idx[1];
                r_q_val[w_slot1] <= w_lane_val[1];
            end
        end
    end

    assign phtWA    = (r_state == S_INIT) ? r_sweep : r_q_idx[r_rptr];
    assign phtWV    = (r_state == S_INIT) ? INIT_VALUE : r_q_val[r_rptr];
    assign count    = rst ? '0 : r_count;
    assign full     = (count > c_full_thresh);
    assign initBusy = rst | (r_state == S_INIT);
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pht_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pht_update_scheduler
// Brief    : Self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pht_update_scheduler;

    localparam int IW = 4;
    localparam int QD = 4;

    logic       clk = 1'b0;
    logic       rst, flush, portBusy;
    logic [1:0] updValid, updIsCondBr, updTaken;
    logic [7:0] updIndex;
    logic [3:0] updPrev;
    logic       phtWE, full, initBusy, overflow;
    logic [3:0] phtWA;
    logic [1:0] phtWV;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    pht_update_scheduler #(.INDEX_WIDTH(IW), .QUEUE_DEPTH(QD), .INIT_VALUE(2'b01)) dut (
        .clk(clk), .rst(rst), .flush(flush), .updValid(updValid),
        .updIsCondBr(updIsCondBr), .updIndex(updIndex), .updPrev(updPrev),
        .updTaken(updTaken), .portBusy(portBusy), .phtWE(phtWE), .phtWA(phtWA),
        .phtWV(phtWV), .full(full), .initBusy(initBusy), .overflow(overflow),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: init flag, sweep position, FIFO of idx*4+value.
    bit m_init  = 1'b1;
    int m_sweep = 0;
    bit m_ovf   = 1'b0;
    int m_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete(); m_init = 1'b1; m_sweep = 0; m_ovf = 1'b0;
        end else if (flush) begin
            m_q.delete(); m_init = 1'b1; m_sweep = 0;
        end else if (m_init) begin
            if (!portBusy) begin
                if (m_sweep == (1 << IW) - 1) begin
                    m_init = 1'b0; m_sweep = 0;
                end else begin
                    m_sweep++;
                end
            end
        end else begin
            if (m_q.size() != 0 && !portBusy) void'(m_q.pop_front());
            for (int l = 0; l < 2; l++) begin
                if (updValid[l] && updIsCondBr[l]) begin
                    int p, v;
                    p = int'(updPrev[2*l +: 2]);
                    v = updTaken[l] ? ((p < 3) ? p + 1 : 3) : ((p > 0) ? p - 1 : 0);
                    if (m_q.size() < QD) m_q.push_back(int'(updIndex[l*IW +: IW]) * 4 + v);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    function automatic logic [12:0] expv();
        logic we, f, ib;
        logic [3:0] wa;
        logic [1:0] wv;
        logic [2:0] c;
        if (rst) begin
            we = 0; wa = 0; wv = 0; f = 0; ib = 1; c = 0;
        end else begin
            we = !flush && !portBusy && (m_init || m_q.size() != 0);
            if (m_init) begin
                wa = 4'(m_sweep); wv = 2'b01;
            end else if (we) begin
                wa = 4'(m_q[0] >> 2); wv = 2'(m_q[0] & 3);
            end else begin
                wa = 0; wv = 0;
            end
            f = (m_q.size() > QD - 2); ib = m_init; c = 3'(m_q.size());
        end
        return {we, wa, wv, f, ib, m_ovf, c};
    endfunction

    function automatic logic [12:0] obs();
        logic show;
        show = !rst && (phtWE || initBusy);
        return {phtWE, show ? phtWA : 4'h0, show ? phtWV : 2'b00, full, initBusy, overflow, count};
    endfunction

    task automatic drive(input logic r, f, b, input logic [1:0] v, c, t,
                         input logic [7:0] idx, input logic [3:0] p);
        rst = r; flush = f; portBusy = b; updValid = v; updIsCondBr = c;
        updTaken = t; updIndex = idx; updPrev = p;
    endtask

    task automatic drive_rand(input logic r, f, b);
        drive(r, f, b, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go_run();
        do_reset();
        repeat (16) begin @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0); end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive_rand(1, 1'($urandom), 1'($urandom)); #1;
            checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_init_sweep();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i < 16) drive(0, 0, 0, 2'b11, 2'b11, 2'($urandom), 8'($urandom), 4'($urandom));
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1; checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL init_sweep cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_sweep_stall();
        int stall = 3;
        int wr[16];
        foreach (wr[k]) wr[k] = 0;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (m_init && m_sweep == 5 && stall > 0) begin
                stall--; drive_rand(0, 0, 1);
            end else begin
                drive_rand(0, 0, 0);
            end
            #1; checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL sweep_stall cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
            if (phtWE && initBusy) wr[phtWA]++;
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (wr[k] !== 1) begin
                failures++; $display("FAIL sweep_once idx=%0d got=%0d exp=1", k, wr[k]);
            end
        end
    endtask

    task automatic test_two_lane();
        go_run();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) drive(0, 0, 0, 2'b11, 2'b11, 2'b01, {4'd9, 4'd7}, {2'd0, 2'd3});
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1; checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL two_lane cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_overflow();
        go_run();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) drive(0, 0, 1, 2'b01, 2'b11, 2'($urandom), 8'($urandom), 4'($urandom));
            else if (i < 3) drive(0, 0, 1, 2'b11, 2'b11, 2'($urandom), 8'($urandom), 4'($urandom));
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1; checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL overflow cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_flush();
        go_run();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 0) drive(0, 0, 1, 2'b01, 2'b01, 2'b01, 8'h0A, 4'h1);
            else if (i == 1) drive(0, 0, 1, 2'b11, 2'b11, 2'b10, 8'h3C, 4'h6);
            else if (i == 2) drive(0, 1, 0, 2'b11, 2'b11, 2'b11, 8'h55, 4'h5);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1; checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL flush cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 3), 2'($urandom), 2'($urandom | $urandom),
                  2'($urandom), 8'($urandom), 4'($urandom));
            #1; checks++;
            if (obs() !== expv()) begin
                failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_init_sweep();
        test_sweep_stall();
        test_two_lane();
        test_overflow();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
